huffman_stream_ctrl: RTL and testbench
======================================

// Module: huffman_stream_ctrl
// PURPOSE
//  Sequences one huffmandecode instance over a JPEG entropy-coded byte stream.
//  - Packs incoming bytes into a left-justified bit window and removes 0xFF00 byte stuffing.
//  - Presents a 16-bit code window, restarts the decoder and waits for it to finish.
//  - Consumes the decoded length, then emits the symbol on a valid/ready port.
//  Sits between the scan byte FIFO and the run-length/coefficient stage.
// PARAMETERS
//  TIMEOUT  64  max cycles waiting for dec_finish before error
//  BUF_W    32  bit-window width; must be >= 24
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      1-cycle pulse: begin a segment, latch cfg_nsym
//  cfg_nsym   in   16     symbols to decode in the segment; 0 = unlimited
//  in_byte    in   8      stream byte
//  in_valid   in   1      in_byte valid
//  in_last    in   1      in_byte is the last byte of the segment
//  in_ready   out  1      byte accepted when in_valid & in_ready
//  dec_code   out  16     buf[BUF_W-1 -: 16], MSB = next bit; unfilled bits read as 1
//  dec_rst_n  out  1      decoder restart, low for exactly 1 cycle per launch
//  dec_data   in   8      decoded symbol from the decoder
//  dec_len    in   8      code length consumed, legal range 1..16
//  dec_finish in   1      decoder result valid
//  sym        out  8      decoded symbol
//  sym_valid  out  1      held until sym_ready
//  sym_ready  in   1      downstream accept
//  busy       out  1      high in every state except IDLE and ERR
//  done       out  1      1-cycle pulse when the segment completes
//  err        out  3      sticky until start/rst: [0] timeout, [1] bad len, [2] marker
// BEHAVIOUR
//  Reset: state=IDLE; bit_cnt=0; buf all 1s; sym_cnt=0; ff_seen=0; last_seen=0.
//   Output reset values: in_ready=0, dec_rst_n=1, sym=0, sym_valid=0, done=0, err=0.
//  in_ready = busy & ~last_seen & (bit_cnt <= BUF_W-8).
//  Accepted byte is written to buf[BUF_W-1-bit_cnt -: 8]; bit_cnt increments by 8.
//  Byte stuffing:
//   - Accepted 0xFF sets ff_seen.
//   - Next byte 0x00 is discarded and clears ff_seen.
//   - Next byte 0xFF keeps ff_seen set (fill byte) and is also discarded.
//   - Any other next byte sets err[2] and moves to ERR.
//  States:
//   IDLE   : start -> FILL. Clears err, sym_cnt, last_seen, ff_seen.
//   FILL   : -> LAUNCH when bit_cnt >= 16, or when last_seen & bit_cnt >= 1.
//            -> DONE when last_seen & bit_cnt == 0.
//   LAUNCH : dec_rst_n=0 for this cycle only; dec_code frozen from here until consume. -> WAIT.
//   WAIT   : wdog counts up from 0.
//            dec_finish & dec_len in 1..16 & dec_len <= bit_cnt -> consume, -> EMIT.
//            Bad dec_len -> err[1], ERR.
//            wdog == TIMEOUT-1 -> err[0], ERR.
//   EMIT   : sym <= dec_data and sym_valid=1 on entry.
//            On sym_valid & sym_ready: sym_cnt++.
//            If cfg_nsym != 0 and sym_cnt+1 == cfg_nsym -> DONE, else -> FILL.
//   DONE   : done=1 for 1 cycle, -> IDLE.
//   ERR    : only start or rst exits; start -> FILL with err cleared.
//  Consume: buf <= (buf << dec_len) | 1s fill in the low bits; bit_cnt -= dec_len.
//   Same-cycle byte accept: shift first, then insert the byte at the new bit_cnt.
//  Latency: FILL (window ready) -> LAUNCH 1 cycle, LAUNCH -> WAIT 1 cycle.
//   Decoder finish -> sym_valid 1 cycle.
//  Simultaneous events:
//   - rst dominates everything.
//   - start outside IDLE/ERR is ignored.
//   - Mid-segment rst aborts with no done pulse.
//  Widths: bit_cnt 6b for BUF_W=32; sym_cnt 16b, wraps when cfg_nsym=0.
// TESTING
//  1 Bytes 0x98,0xD0(last); decoder model returns len 2/data 0x02, then len 3/data 0x03
//    -> sym 0x02 then 0x03; bit_cnt 16->14->11.
//  2 Bytes 0xFF,0x00,0x12 -> decoder sees dec_code=0xFF12; stuffed 0x00 never enters buf.
//  3 Bytes 0xFF,0xD9 -> err=3'b100, state ERR, in_ready=0; start -> err cleared, FILL.
//  4 Decoder model never asserts dec_finish -> err[0] set exactly TIMEOUT cycles after LAUNCH.
//  5 cfg_nsym=3, sym_ready low for 5 cycles per symbol -> sym held stable while stalled;
//    exactly 3 symbols emitted; done pulses once.
//  6 rst asserted in WAIT -> next cycle all outputs at reset values; dec_rst_n stays 1.

Source files
------------

// File: rtl/huffman_stream_ctrl.sv
// ============================================================================
// huffman_stream_ctrl
// ----------------------------------------------------------------------------
// Runs one huffmandecode instance over a JPEG entropy-coded byte stream.
// Incoming bytes are packed into a left-justified bit window, and 0xFF00 byte
// stuffing is removed on the way in. The top 16 bits of the window are
// presented to the decoder. The decoder is restarted for each symbol. Its
// reported code length is shifted out of the window, and the decoded symbol is
// then offered downstream on a valid/ready port.
//
// Parameters
//   TIMEOUT  cycles to wait for dec_finish before flagging a timeout
//   BUF_W    bit-window width (>= 24)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           1-cycle pulse, begins a segment and latches cfg_nsym
//   cfg_nsym [15:0] symbols per segment, 0 = unlimited
//   in_byte/in_valid/in_last/in_ready   byte stream input (valid/ready)
//   dec_code [15:0] code window to the decoder, MSB = next bit
//   dec_rst_n       decoder restart, low for one cycle per launch
//   dec_data/dec_len/dec_finish         decoder result
//   sym/sym_valid/sym_ready             decoded symbol output (valid/ready)
//   busy            high outside IDLE and ERR
//   done            1-cycle pulse at segment completion
//   err [2:0]       sticky: [0] timeout, [1] bad length, [2] marker in stream
// ============================================================================
module huffman_stream_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int BUF_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_nsym,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] dec_code,
  output logic        dec_rst_n,
  input  logic [7:0]  dec_data,
  input  logic [7:0]  dec_len,
  input  logic        dec_finish,
  output logic [7:0]  sym,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ROOM  = CNT_W'(BUF_W - 8);
  localparam logic [CNT_W-1:0] CNT_CODE  = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_BYTE  = CNT_W'(8);
  localparam logic [WD_W-1:0]  WDOG_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [BUF_W-1:0] INS_MASK  = {8'hFF, {(BUF_W-8){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_WAIT,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [15:0]        r_sym_cnt;
  logic [15:0]        r_nsym;
  logic               r_ff_seen;
  logic               r_last_seen;
  logic [WD_W-1:0]    r_wdog;
  logic [7:0]         r_sym;
  logic               r_sym_valid;
  logic [2:0]         r_err;

  logic               w_busy;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_store;
  logic               w_marker;
  logic               w_len_ok;
  logic               w_consume;
  logic               w_bad_len;
  logic               w_timeout;
  logic               w_handshake;
  logic               w_last_sym;
  logic               w_start_ok;
  logic [BUF_W-1:0]   w_buf_next;
  logic [CNT_W-1:0]   w_cnt_next;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_in_ready = w_busy && !r_last_seen && (r_bit_cnt <= CNT_ROOM);
  assign w_accept   = in_valid && w_in_ready;

  // The byte after an 0xFF is never data. 0x00 (stuffing) and 0xFF (fill) are
  // dropped, and anything else is a marker, which ends the scan in error.
  assign w_store  = w_accept && !r_ff_seen;
  assign w_marker = w_accept && r_ff_seen && (in_byte != 8'h00) && (in_byte != 8'hFF);

  // A length longer than the bits actually held means the decoder ran past
  // the end of the segment, so it is treated as a bad length.
  assign w_len_ok = (dec_len != 8'd0) && (dec_len <= 8'd16) &&
                    (32'(dec_len) <= 32'(r_bit_cnt));

  assign w_consume   = (r_state == S_WAIT) && dec_finish && w_len_ok;
  assign w_bad_len   = (r_state == S_WAIT) && dec_finish && !w_len_ok;
  assign w_timeout   = (r_state == S_WAIT) && !dec_finish && (r_wdog == WDOG_LAST);
  assign w_handshake = (r_state == S_EMIT) && r_sym_valid && sym_ready;
  assign w_last_sym  = (r_nsym != 16'd0) && ((r_sym_cnt + 16'd1) == r_nsym);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_ERR));

  // --------------------------------------------------------------------------
  // Bit-window datapath: shift out the consumed code first, then drop a new
  // byte in just below the remaining valid bits. Vacated bits refill with 1s.
  // --------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later lines see the value
  // computed above them. Every output also gets a default on entry, which
  // prevents a latch from being inferred on paths that do not assign it.
  always_comb begin
    w_buf_next = r_buf;
    w_cnt_next = r_bit_cnt;
    if (w_consume) begin
      w_buf_next = (r_buf << dec_len) | ~({BUF_W{1'b1}} << dec_len);
      w_cnt_next = r_bit_cnt - CNT_W'(dec_len);
    end
    if (w_store) begin
      w_buf_next = (w_buf_next & ~(INS_MASK >> w_cnt_next)) |
                   ({in_byte, {(BUF_W-8){1'b0}}} >> w_cnt_next);
      w_cnt_next = w_cnt_next + CNT_BYTE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_next = S_FILL;
      S_FILL: begin
        if (r_last_seen && (r_bit_cnt == '0))
          w_state_next = S_DONE;
        else if ((r_bit_cnt >= CNT_CODE) || (r_last_seen && (r_bit_cnt != '0)))
          w_state_next = S_LAUNCH;
      end
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_bad_len || w_timeout) w_state_next = S_ERR;
        else if (w_consume)         w_state_next = S_EMIT;
      end
      S_EMIT:   if (w_handshake) w_state_next = w_last_sym ? S_DONE : S_FILL;
      S_DONE:   w_state_next = S_IDLE;
      S_ERR:    if (start) w_state_next = S_FILL;
      default:  w_state_next = S_IDLE;
    endcase
    // A marker can arrive in any state that accepts bytes.
    if (w_marker) w_state_next = S_ERR;
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = w_busy;
    in_ready  = w_in_ready;
    dec_rst_n = (r_state != S_LAUNCH);
    done      = (r_state == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '1;
      r_bit_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_nsym      <= '0;
      r_ff_seen   <= 1'b0;
      r_last_seen <= 1'b0;
      r_wdog      <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      r_buf     <= w_buf_next;
      r_bit_cnt <= w_cnt_next;

      if (w_accept) begin
        if (in_last) r_last_seen <= 1'b1;
        if (r_ff_seen) begin
          if (in_byte == 8'h00) r_ff_seen <= 1'b0;
        end else if (in_byte == 8'hFF) begin
          r_ff_seen <= 1'b1;
        end
      end

      if (r_state == S_LAUNCH)    r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;

      if (w_consume) begin
        r_sym       <= dec_data;
        r_sym_valid <= 1'b1;
      end
      if (w_handshake || w_marker) r_sym_valid <= 1'b0;
      if (w_handshake)             r_sym_cnt   <= r_sym_cnt + 16'd1;

      if (w_timeout) r_err[0] <= 1'b1;
      if (w_bad_len) r_err[1] <= 1'b1;
      if (w_marker)  r_err[2] <= 1'b1;

      // Start is only honoured while no bytes can be accepted, so it never
      // collides with the stream updates above.
      if (w_start_ok) begin
        r_err       <= '0;
        r_sym_cnt   <= '0;
        r_last_seen <= 1'b0;
        r_ff_seen   <= 1'b0;
        r_nsym      <= cfg_nsym;
      end
    end
  end

  assign dec_code  = r_buf[BUF_W-1 -: 16];
  assign sym       = r_sym;
  assign sym_valid = r_sym_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// ============================================================================
// tb_huffman_stream_ctrl
// Directed bench. The stimulus queues the decoder responses it expects to
// serve and the symbols it expects to see. A decoder model pops responses on
// each launch. A separate monitor pops expected symbols whenever the DUT
// presents one.
// ============================================================================
module tb_huffman_stream_ctrl;

  localparam int TIMEOUT = 64;
  localparam int BUF_W   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_nsym;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] dec_code;
  logic        dec_rst_n;
  logic [7:0]  dec_data;
  logic [7:0]  dec_len;
  logic        dec_finish;
  logic [7:0]  sym;
  logic        sym_valid;
  logic        sym_ready;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  always #5 clk = ~clk;

  huffman_stream_ctrl #(.TIMEOUT(TIMEOUT), .BUF_W(BUF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_nsym   (cfg_nsym),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .dec_code   (dec_code),
    .dec_rst_n  (dec_rst_n),
    .dec_data   (dec_data),
    .dec_len    (dec_len),
    .dec_finish (dec_finish),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [15:0] code;   // expected dec_code at launch
    logic [7:0]  len;
    logic [7:0]  data;
    int          delay;  // extra WAIT cycles before finishing
    bit          fin;    // 0: never finish
    int          bcnt;   // expected bit count at launch, -1 = don't care
  } dec_resp_t;

  dec_resp_t  dec_q[$];
  logic [7:0] sym_q[$];
  int checks    = 0;
  int errors    = 0;
  int stall_cfg = 0;
  int done_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seg(input logic [15:0] n);
    cfg_nsym = n;
    start    = 1'b1;
    sync();
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("byte_accepted", in_ready, 1'b1);
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int exp, input int budget);
    int n = 0;
    while (done_cnt < exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, exp);
    sync();
  endtask

  task automatic wait_launch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dec_rst_n && n < 100);
    check("launch_seen", dec_rst_n, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    done_cnt = 0;
  endtask

  // Decoder model: serves one queued response per launch.
  initial begin
    dec_resp_t r;
    dec_finish = 1'b0;
    dec_len    = '0;
    dec_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst && !dec_rst_n) begin
        if (dec_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_launch unexpected launch, code=%0h", dec_code);
        end else begin
          r = dec_q.pop_front();
          check("dec_code", dec_code, r.code);
          if (r.bcnt >= 0) check("bit_cnt_at_launch", dut.r_bit_cnt, r.bcnt);
          if (r.fin) begin
            @(posedge clk);
            repeat (r.delay) @(posedge clk);
            #1;
            dec_finish = 1'b1;
            dec_len    = r.len;
            dec_data   = r.data;
            @(posedge clk);
            #1;
            dec_finish = 1'b0;
          end
        end
      end
    end
  end

  // Downstream ready: holds off stall_cfg cycles for each offered symbol.
  initial begin
    int wait_cnt = 0;
    sym_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!sym_valid) begin
        sym_ready = 1'b0;
        wait_cnt  = 0;
      end else if (wait_cnt < stall_cfg) begin
        sym_ready = 1'b0;
        wait_cnt++;
      end else begin
        sym_ready = 1'b1;
      end
    end
  end

  // Symbol monitor. While stalled, the symbol must equal the pending expected
  // one. It is popped when it is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (sym_valid) begin
        if (sym_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sym unexpected actual=%0h", sym);
        end else begin
          check(sym_ready ? "sym" : "sym_hold", sym, sym_q[0]);
          if (sym_ready) void'(sym_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cfg_nsym = '0;
    in_byte  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_dec_rst_n", dec_rst_n, 1'b1);
    check("rst_sym", sym, 8'h00);
    check("rst_sym_valid", sym_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_dec_code", dec_code, 16'hFFFF);
    sync();

    // 1: 0x98,0xD0(last), unlimited count. Codes 10 / 011 / 11 remaining bits.
    dec_q.push_back('{16'h98D0, 8'd2,  8'h02, 0, 1'b1, 16});
    dec_q.push_back('{16'h6343, 8'd3,  8'h03, 1, 1'b1, 14});
    dec_q.push_back('{16'h1A1F, 8'd11, 8'h0B, 0, 1'b1, 11});
    sym_q.push_back(8'h02);
    sym_q.push_back(8'h03);
    sym_q.push_back(8'h0B);
    start_seg(16'd0);
    send_byte(8'h98, 1'b0);
    send_byte(8'hD0, 1'b1);
    wait_done(1, 400);
    check("t1_bit_cnt_end", dut.r_bit_cnt, 0);
    do_reset();

    // 2: stuffed 0x00 is removed; window reads FF12. Length 16 is legal.
    dec_q.push_back('{16'hFF12, 8'd16, 8'h55, 0, 1'b1, -1});
    sym_q.push_back(8'h55);
    start_seg(16'd1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    wait_done(1, 400);
    do_reset();

    // 5: three symbols with 5 stall cycles each; done pulses once.
    stall_cfg = 5;
    dec_q.push_back('{16'h1234, 8'd4, 8'hA1, 0, 1'b1, -1});
    dec_q.push_back('{16'h2345, 8'd4, 8'hA2, 2, 1'b1, -1});
    dec_q.push_back('{16'h3456, 8'd4, 8'hA3, 0, 1'b1, -1});
    sym_q.push_back(8'hA1);
    sym_q.push_back(8'hA2);
    sym_q.push_back(8'hA3);
    start_seg(16'd3);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    wait_done(1, 600);
    repeat (20) sync();
    check("t5_single_done", done_cnt, 1);
    stall_cfg = 0;
    do_reset();

    // 3: marker 0xFF,0xD9, then restart from ERR.
    start_seg(16'd1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hD9, 1'b0);
    @(negedge clk);
    check("t3_err_marker", err, 3'b100);
    check("t3_in_ready", in_ready, 1'b0);
    check("t3_busy_err", busy, 1'b0);
    sync();
    start_seg(16'd1);
    @(negedge clk);
    check("t3_err_cleared", err, 3'b000);
    check("t3_busy_fill", busy, 1'b1);
    sync();
    do_reset();

    // 4: decoder never finishes. After LAUNCH ends, err[0] appears after
    // exactly TIMEOUT WAIT cycles.
    dec_q.push_back('{16'h1122, 8'd0, 8'h00, 0, 1'b0, -1});
    start_seg(16'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    wait_launch();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!err[0] && n < 200);
      check("t4_timeout_latency", n, TIMEOUT + 1);
    end
    check("t4_err_timeout", err, 3'b001);
    check("t4_busy", busy, 1'b0);
    sync();
    do_reset();

    // Bad length (0) gives err[1].
    dec_q.push_back('{16'h3344, 8'd0, 8'hAA, 0, 1'b1, -1});
    start_seg(16'd1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (err == 3'b000 && n < 100);
    end
    check("bad_len_err", err, 3'b010);
    sync();
    do_reset();

    // 6: reset in WAIT aborts with reset outputs and no done pulse.
    dec_q.push_back('{16'h5566, 8'd0, 8'h00, 0, 1'b0, -1});
    start_seg(16'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    wait_launch();
    sync();
    sync();
    check("t6_busy_wait", busy, 1'b1);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("t6_in_ready", in_ready, 1'b0);
    check("t6_dec_rst_n", dec_rst_n, 1'b1);
    check("t6_sym", sym, 8'h00);
    check("t6_sym_valid", sym_valid, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_err", err, 3'b000);
    check("t6_busy", busy, 1'b0);
    check("t6_dec_code", dec_code, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_dec_rst_n_hold", dec_rst_n, 1'b1);
    end
    check("t6_no_done", done_cnt, 0);
    sync();

    check("sym_queue_drained", sym_q.size(), 0);
    check("dec_queue_drained", dec_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
